// File: rtl/ibus_fetch_queue_pkg.sv
// Shared types for the instruction-fetch front end.
// Entry bundle, fetch FSM states and reset constants.
package ibus_fetch_queue_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_DROP
  } fetch_state_t;

  localparam word_t FETCH_RESET_PC = 32'hbfc0_0000;

  // An unaligned response only carries the upper word.
  function automatic logic [1:0] push_count(input logic index);
    return index ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/ibus_fetch_queue_fifo.sv
// Circular buffer of fetched (pc, inst) pairs.
// Two pushes and two pops per cycle; exposes head and head+1.
module ibus_fetch_queue_fifo
  import ibus_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic [1:0]               push_num,
  input  fetch_entry_t             push0,
  input  fetch_entry_t             push1,
  input  logic [1:0]               pop_num,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head0,
  output fetch_entry_t             head1
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   mem_d [DEPTH];
  logic [AW-1:0]  head_q, head_d;
  logic [AW-1:0]  tail_q, tail_d;
  logic [AW:0]    count_q, count_d;

  always_comb begin
    mem_d = mem_q;
    if (push_num != 2'd0) mem_d[tail_q] = push0;
    if (push_num == 2'd2) mem_d[tail_q + AW'(1)] = push1;
    head_d  = head_q + AW'(pop_num);
    tail_d  = tail_q + AW'(push_num);
    count_d = count_q + (AW+1)'(push_num)
                      - (AW+1)'(pop_num);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: validity comes from count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (resetn && !flush) begin
      assert (pop_num <= 2'd2 && (AW+1)'(pop_num) <= count_q)
        else $error("dequeue exceeds fifo occupancy");
    end
  end

  assign count = count_q;
  assign head0 = mem_q[head_q];
  assign head1 = mem_q[head_q + AW'(1)];

endmodule

// File: rtl/ibus_fetch_queue.sv
// Instruction-fetch front end: one-outstanding ibus requester
// feeding a dual-output instruction queue for decode.
module ibus_fetch_queue
  import ibus_fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int          DEPTH    = 8
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             inst_ibus_req,
  output logic [31:0]      inst_ibus_addr,
  input  logic             inst_ibus_addr_ok,
  input  logic             inst_ibus_data_ok,
  input  logic [63:0]      inst_ibus_data,
  input  logic             inst_ibus_index,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic [1:0]       deq_num,
  output logic [1:0]       out_valid,
  output logic [1:0][31:0] out_pc,
  output logic [1:0][31:0] out_inst
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  word_t         fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count;
  fetch_entry_t  head0, head1;
  fetch_entry_t  push0, push1;
  logic [1:0]    push_num;
  logic [1:0]    pop_num;
  logic          accepted;

  // Request only when a full aligned pair is guaranteed to fit.
  assign inst_ibus_req  = (state_q == FS_REQ) &&
                          (count <= CW'(DEPTH - 2));
  assign inst_ibus_addr = fetch_pc_q;
  assign accepted       = inst_ibus_req && inst_ibus_addr_ok;
  assign pop_num        = redirect ? 2'd0 : deq_num;

  always_comb begin
    push0.pc   = fetch_pc_q;
    push0.inst = inst_ibus_index ? inst_ibus_data[63:32]
                                 : inst_ibus_data[31:0];
    push1.pc   = fetch_pc_q + 32'd4;
    push1.inst = inst_ibus_data[63:32];
    push_num   = 2'd0;
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      FS_REQ: begin
        if (accepted)
          state_d = redirect ? FS_DROP : FS_WAIT;
      end
      FS_WAIT: begin
        if (inst_ibus_data_ok) begin
          state_d = FS_REQ;
          if (!redirect) begin
            push_num   = push_count(inst_ibus_index);
            fetch_pc_d = fetch_pc_q +
              (inst_ibus_index ? 32'd4 : 32'd8);
          end
        end else if (redirect) begin
          state_d = FS_DROP;
        end
      end
      FS_DROP: begin
        if (inst_ibus_data_ok) state_d = FS_REQ;
      end
      default: state_d = FS_REQ;
    endcase
    if (redirect) fetch_pc_d = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= FS_REQ;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  ibus_fetch_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (redirect),
    .push_num (push_num),
    .push0    (push0),
    .push1    (push1),
    .pop_num  (pop_num),
    .count    (count),
    .head0    (head0),
    .head1    (head1)
  );

  assign out_valid   = {count >= CW'(2), count >= CW'(1)};
  assign out_pc[0]   = head0.pc;
  assign out_pc[1]   = head1.pc;
  assign out_inst[0] = head0.inst;
  assign out_inst[1] = head1.inst;

endmodule

// File: tb/tb_ibus_fetch_queue.sv
// Random and directed bench for ibus_fetch_queue against a
// queue-based reference model of the fetch stream.
module tb_ibus_fetch_queue;

  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             inst_ibus_req;
  logic [31:0]      inst_ibus_addr;
  logic             inst_ibus_addr_ok = 1'b0;
  logic             inst_ibus_data_ok = 1'b0;
  logic [63:0]      inst_ibus_data = '0;
  logic             inst_ibus_index = 1'b0;
  logic             redirect = 1'b0;
  logic [31:0]      redirect_pc = '0;
  logic [1:0]       deq_num = '0;
  logic [1:0]       out_valid;
  logic [1:0][31:0] out_pc;
  logic [1:0][31:0] out_inst;

  always #5 clk = ~clk;

  ibus_fetch_queue #(
    .RESET_PC (32'hbfc0_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_ibus_req     (inst_ibus_req),
    .inst_ibus_addr    (inst_ibus_addr),
    .inst_ibus_addr_ok (inst_ibus_addr_ok),
    .inst_ibus_data_ok (inst_ibus_data_ok),
    .inst_ibus_data    (inst_ibus_data),
    .inst_ibus_index   (inst_ibus_index),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .deq_num           (deq_num),
    .out_valid         (out_valid),
    .out_pc            (out_pc),
    .out_inst          (out_inst)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mq_pc[$];
  logic [31:0] mq_inst[$];
  logic [31:0] m_pc;
  bit          m_out;
  bit          m_stale;

  bit          b_pend;
  logic [31:0] b_addr;
  int          b_lat;

  int          ack_mode;
  int          lat_fixed;
  int          deq_mode;
  int          redir_pct;
  bit          force_redir;
  logic [31:0] force_rpc;
  bit          ovr_en;
  logic [63:0] ovr_data;
  bit          seq_chk;
  bit          have_last;
  logic [31:0] last_pc;
  int          n_resp;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h2400, a[31:16] ^ a[15:0]};
  endfunction

  task automatic compare_model();
    int sz;
    bit er;
    sz = mq_pc.size();
    er = !m_out && ((DEPTH - sz) >= 2);
    chk("req", inst_ibus_req, er);
    if (er) chk("addr", inst_ibus_addr, m_pc);
    chk("valid", out_valid, {sz >= 2, sz >= 1});
    if (sz >= 1) begin
      chk("pc0", out_pc[0], mq_pc[0]);
      chk("inst0", out_inst[0], mq_inst[0]);
    end
    if (sz >= 2) begin
      chk("pc1", out_pc[1], mq_pc[1]);
      chk("inst1", out_inst[1], mq_inst[1]);
    end
  endtask

  task automatic tick();
    bit aok, dok, rd;
    logic [1:0] dq;
    logic [31:0] rpc;
    logic [31:0] base;
    int sz, mx;
    sz = mq_pc.size();
    case (ack_mode)
      1:       aok = 1'b1;
      2:       aok = 1'b0;
      default: aok = ($urandom % 2) == 1;
    endcase
    aok = aok && inst_ibus_req;
    dok = 1'b0;
    if (b_pend) begin
      if (b_lat == 0) dok = 1'b1;
      else b_lat--;
    end
    rd  = force_redir || ($urandom_range(99, 0) < redir_pct);
    rpc = force_redir ? force_rpc : ($urandom & 32'hffff_fffc);
    force_redir = 1'b0;
    mx = (sz < 2) ? sz : 2;
    case (deq_mode)
      1:       dq = 2'd0;
      2:       dq = (sz >= 2) ? 2'd2 : 2'd0;
      default: dq = 2'($urandom_range(mx, 0));
    endcase
    inst_ibus_addr_ok = aok;
    inst_ibus_data_ok = dok;
    redirect          = rd;
    redirect_pc       = rpc;
    deq_num           = dq;
    if (dok) begin
      base = {b_addr[31:3], 3'b000};
      inst_ibus_index = b_addr[2];
      inst_ibus_data  = ovr_en ? ovr_data
                      : {mem_word(base + 32'd4), mem_word(base)};
      ovr_en = 1'b0;
    end else begin
      inst_ibus_index = 1'($urandom);
      inst_ibus_data  = {$urandom, $urandom};
    end
    if (seq_chk && !rd && dq == 2'd2) begin
      chk("seq_pair", out_pc[1], out_pc[0] + 32'd4);
      if (have_last) chk("seq_gap", out_pc[0], last_pc + 32'd4);
      last_pc   = out_pc[1];
      have_last = 1'b1;
    end
    if (!rd) begin
      repeat (dq) begin
        void'(mq_pc.pop_front());
        void'(mq_inst.pop_front());
      end
    end
    if (dok) begin
      n_resp++;
      if (!m_stale && !rd) begin
        mq_pc.push_back(b_addr);
        mq_inst.push_back(inst_ibus_index ? inst_ibus_data[63:32]
                                          : inst_ibus_data[31:0]);
        if (!inst_ibus_index) begin
          mq_pc.push_back(b_addr + 32'd4);
          mq_inst.push_back(inst_ibus_data[63:32]);
        end
        m_pc = b_addr + (inst_ibus_index ? 32'd4 : 32'd8);
      end
      m_out   = 1'b0;
      m_stale = 1'b0;
      b_pend  = 1'b0;
    end
    if (rd) begin
      mq_pc.delete();
      mq_inst.delete();
      m_pc = rpc;
      if (m_out) m_stale = 1'b1;
    end
    if (aok) begin
      m_out   = 1'b1;
      m_stale = rd;
      b_pend  = 1'b1;
      b_addr  = inst_ibus_addr;
      b_lat   = (lat_fixed >= 0) ? lat_fixed : $urandom_range(3, 0);
    end
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    mq_pc.delete();
    mq_inst.delete();
    m_pc = 32'hbfc0_0000;
    m_out = 0; m_stale = 0; b_pend = 0; b_lat = 0; b_addr = '0;
    ack_mode = 2; lat_fixed = 0; deq_mode = 1; redir_pct = 0;
    force_redir = 0; force_rpc = '0; ovr_en = 0; ovr_data = '0;
    seq_chk = 0; have_last = 0; last_pc = '0; n_resp = 0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    compare_model();
    chk("rst_req", inst_ibus_req, 1);
    chk("rst_addr", inst_ibus_addr, 32'hbfc0_0000);
    chk("rst_valid", out_valid, 2'b00);

    // Aligned fetch of a known block
    ack_mode = 1;
    ovr_en   = 1;
    ovr_data = 64'h2402_0002_2401_0001;
    tick();
    tick();
    chk("al_valid", out_valid, 2'b11);
    chk("al_pc", out_pc, {32'hbfc0_0004, 32'hbfc0_0000});
    chk("al_inst", out_inst, {32'h2402_0002, 32'h2401_0001});
    chk("al_addr", inst_ibus_addr, 32'hbfc0_0008);

    // Unaligned restart
    ack_mode = 2;
    force_redir = 1; force_rpc = 32'hbfc0_0014;
    tick();
    ack_mode = 1;
    tick();
    tick();
    chk("ua_valid", out_valid, 2'b01);
    chk("ua_pc", out_pc[0], 32'hbfc0_0014);
    chk("ua_inst", out_inst[0], mem_word(32'hbfc0_0014));
    chk("ua_req", inst_ibus_req, 1);
    chk("ua_addr", inst_ibus_addr, 32'hbfc0_0018);

    // Back-pressure with a full queue
    ack_mode = 2;
    force_redir = 1; force_rpc = 32'h0000_1000;
    tick();
    ack_mode = 1;
    repeat (8) tick();
    chk("bp_valid", out_valid, 2'b11);
    chk("bp_full", inst_ibus_req, 0);
    repeat (2) begin
      tick();
      chk("bp_hold", inst_ibus_req, 0);
    end
    deq_mode = 2;
    tick();
    chk("bp_req", inst_ibus_req, 1);
    deq_mode = 1;

    // Stale response after a redirect
    lat_fixed = 3;
    tick();
    ack_mode = 2;
    force_redir = 1; force_rpc = 32'h8000_1000;
    tick();
    chk("drop_valid", out_valid, 2'b00);
    chk("drop_req", inst_ibus_req, 0);
    repeat (2) tick();
    chk("drop_wait", inst_ibus_req, 0);
    tick();
    chk("drop_valid2", out_valid, 2'b00);
    chk("drop_req2", inst_ibus_req, 1);
    chk("drop_addr", inst_ibus_addr, 32'h8000_1000);

    // Sequential stream across the wrap point
    ack_mode = 0; lat_fixed = -1; deq_mode = 2;
    seq_chk = 1; have_last = 0; n_resp = 0;
    for (int i = 0; i < 400 && n_resp < 20; i++) tick();
    chk("wrap_resp", n_resp, 20);
    seq_chk = 0;

    // Fully random traffic
    deq_mode = 0; redir_pct = 5;
    repeat (3000) tick();
    redir_pct = 0;
    repeat (1000) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ibus_fetch_queue.md
Name: ibus_fetch_queue

Overview:
- Instruction-fetch front end for the dual-issue in-order core.
- Issues fetch requests on the 64-bit instruction bus (ibus) and buffers returned instructions with their PCs in a circular queue.
- Presents up to two instructions per cycle to decode.
- Sits between the ibus interface at the CPU top level and the decode stage inside the datapath.
- Handles branch/exception redirects, including discarding a response that is already in flight.

Parameters:
- RESET_PC, 32'hbfc0_0000, first virtual fetch address after reset.
- DEPTH, 8, queue entries; power of two, >= 4.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset, sampled on posedge clk.
- inst_ibus_req  out  1  fetch request valid.
- inst_ibus_addr  out  32  virtual fetch PC. Top level translates it.
- inst_ibus_addr_ok  in  1  request accepted this cycle.
- inst_ibus_data_ok  in  1  response valid this cycle.
- inst_ibus_data  in  64  [31:0] = word at PC&~7; [63:32] = word at (PC&~7)+4.
- inst_ibus_index  in  1  equals bit 2 of the request PC. 1 means only [63:32] is valid.
- redirect  in  1  flush the queue and restart at redirect_pc.
- redirect_pc  in  32  new fetch PC, word aligned.
- deq_num  in  2  instructions decode consumes this cycle (0..2).
- out_valid  out  2  bit0 = slot0 valid, bit1 = slot1 valid. bit1 implies bit0.
- out_pc  out  2x32  PCs of slot0 and slot1.
- out_inst  out  2x32  instructions of slot0 and slot1.

Behaviour:
- Reset:
  - req=0, out_valid=0, queue empty, fetch_pc=RESET_PC, state=REQ.
  - In-flight bus transactions are forgotten. The bus is also reset.
- States:
  - REQ: req=1 while free entries >= 2, otherwise req=0 and wait. addr=fetch_pc. On addr_ok go to WAIT.
  - WAIT: req=0. On data_ok:
    - index=0: push (fetch_pc, data[31:0]) then (fetch_pc+4, data[63:32]); fetch_pc += 8.
    - index=1: push (fetch_pc, data[63:32]) only; fetch_pc += 4.
    - Then go to REQ. The free-space check in REQ guarantees the pushes never overflow.
  - DROP: req=0. Wait for data_ok, discard the data, go to REQ.
- Redirect, in all cases: queue count -> 0 next cycle, out_valid=0 next cycle, fetch_pc <= redirect_pc.
  - REQ without addr_ok: go to REQ; the new address is presented next cycle.
  - REQ with addr_ok in the same cycle: the accepted request is stale; go to DROP.
  - WAIT without data_ok: go to DROP.
  - WAIT with data_ok in the same cycle: discard the data; go to REQ.
  - DROP: stay in DROP, or go to REQ if data_ok arrives.
  - Any deq_num in the same cycle is ignored.
- Only one outstanding request at a time. inst_ibus_addr stays constant while req=1 and addr_ok=0, except after a redirect.
- Queue:
  - Head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
  - out slot0 = head entry, slot1 = head+1 (wrapping).
  - out_valid = {count>=2, count>=1}, combinational from registered state.
- Dequeue and enqueue in the same cycle are both applied. Count update is count + pushes - deq_num.
- deq_num greater than count is a decode bug. Assert in simulation; RTL behaviour is undefined.
- PC arithmetic is 32-bit with wrap-around. No alignment check; fetch exceptions are handled in decode.

Decomposition:
- Shared package (mips.svh):
  - fetch_entry_t {word_t pc; word_t inst;}
  - fetch_state_t enum {REQ, WAIT, DROP}
  - FETCH_RESET_PC constant
- Sub-module fetch_fifo: a DEPTH-entry, 2-push/2-pop circular buffer exposing count, head and head+1 entries.
- The FSM and PC logic stay in ibus_fetch_queue.

Test Plan:
- Reset then idle bus:
  - Release resetn.
  - Required: req=1 and addr=bfc00000 on the first cycle after reset; out_valid=00.
- Aligned fetch:
  - Stimulus: addr_ok, then data_ok with data=64'h2402_0002_2401_0001, index=0.
  - Required next cycle: out_valid=11, out_pc={bfc00004, bfc00000}, out_inst={24020002, 24010001}; next addr=bfc00008.
- Unaligned fetch:
  - Stimulus: redirect_pc=bfc00014, then index=1 response.
  - Required: single entry pc=bfc00014 with inst=data[63:32]; next addr=bfc00018.
- Back-pressure:
  - Stimulus: deq_num=0 while fetching aligned blocks.
  - Required: after 4 responses count=8 and req held 0; deq_num=2 lets req reassert next cycle.
- Stale response drop:
  - Stimulus: redirect to 80001000 one cycle after addr_ok, then data_ok arrives 3 cycles later.
  - Required: data not enqueued, out_valid=00, then req=1 with addr=80001000.
- Pointer wrap with simultaneous push/pop:
  - Stimulus: 20 aligned fetches with deq_num=2 each cycle slot1 is valid.
  - Required: output PCs strictly sequential by +4 with no gap or duplicate across the DEPTH boundary.
